// File: rtl/rebble_display_pkg.sv
// Shared opcodes, status-byte layout and FSM state type for the Rebble display receiver.
// Optional row-addressed mode is enabled in the top by defining REBBLE_ROW_ADDR_EN.
package rebble_display_pkg;

  localparam logic [7:0] CMD_DRAW   = 8'h05;
  localparam logic [7:0] CMD_STATUS = 8'h03;
  localparam logic [7:0] CMD_CLRINT = 8'h07;

  localparam int STAT_READY = 0;
  localparam int STAT_BUSY  = 1;
  localparam int STAT_INT   = 2;
  localparam int STAT_ERR   = 3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CMD,
    ST_ARMED,
    ST_DATA,
    ST_STAT
  } state_e;

  function automatic logic [7:0] status_byte(input logic err, input logic int_pend,
                                             input logic busy, input logic ready);
    logic [7:0] s;
    s             = '0;
    s[STAT_ERR]   = err;
    s[STAT_INT]   = int_pend;
    s[STAT_BUSY]  = busy;
    s[STAT_READY] = ready;
    return s;
  endfunction

endpackage

// File: rtl/rebble_display_rx_spi_byte_rx.sv
// SPI mode-0 slave front end: synchronisers, edge detection, byte assembly and miso shifter.
// All event outputs are registered so byte and cs pulses reach the FSM in the same cycle.
module spi_byte_rx #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       cs_i,
  input  logic       sck_i,
  input  logic       mosi_i,
  input  logic       tx_load_i,
  input  logic [7:0] tx_byte_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       cs_fall_o,
  output logic       cs_rise_o,
  output logic       miso_o
);

  logic [2:0] cs_q, sck_q;
  logic [1:0] mosi_q;
  logic       cs_fall, cs_rise, sck_rise, sck_fall, sample;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, byte_q, byte_d;
  logic       byte_valid_q, byte_valid_d, cs_fall_q, cs_rise_q;
  logic [7:0] tx_q, tx_d;
  logic [3:0] tx_cnt_q, tx_cnt_d;
  logic       tx_act_q, tx_act_d;

  assign cs_fall  = cs_q[2] & ~cs_q[1];
  assign cs_rise  = ~cs_q[2] & cs_q[1];
  assign sck_rise = ~sck_q[2] & sck_q[1];
  assign sck_fall = sck_q[2] & ~sck_q[1];
  // Gate on the delayed cs so a final bit coinciding with cs rise still counts.
  assign sample   = sck_rise & ~cs_q[2];

  always_comb begin
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    if (sample) begin
      rx_d      = LSB_FIRST ? {mosi_q[1], rx_q[7:1]} : {rx_q[6:0], mosi_q[1]};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_valid_d = 1'b1;
        byte_d       = rx_d;
      end
    end
    if (cs_fall || cs_rise) bit_cnt_d = '0;
  end

  // tx_cnt counts status-byte rises; the shift happens on the fall after each one.
  always_comb begin
    tx_d     = tx_q;
    tx_cnt_d = tx_cnt_q;
    tx_act_d = tx_act_q;
    if (tx_load_i) begin
      tx_d     = tx_byte_i;
      tx_cnt_d = '0;
      tx_act_d = 1'b1;
    end else if (cs_rise) begin
      tx_act_d = 1'b0;
    end else if (tx_act_q) begin
      if (sample) begin
        tx_cnt_d = tx_cnt_q + 4'd1;
      end else if (sck_fall && tx_cnt_q != 4'd0) begin
        if (tx_cnt_q == 4'd8) tx_act_d = 1'b0;
        else tx_d = LSB_FIRST ? {1'b0, tx_q[7:1]} : {tx_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cs_q         <= 3'b111;
      sck_q        <= '0;
      mosi_q       <= '0;
      bit_cnt_q    <= '0;
      rx_q         <= '0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      cs_fall_q    <= 1'b0;
      cs_rise_q    <= 1'b0;
      tx_q         <= '0;
      tx_cnt_q     <= '0;
      tx_act_q     <= 1'b0;
    end else begin
      cs_q         <= {cs_q[1:0], cs_i};
      sck_q        <= {sck_q[1:0], sck_i};
      mosi_q       <= {mosi_q[0], mosi_i};
      bit_cnt_q    <= bit_cnt_d;
      rx_q         <= rx_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      cs_fall_q    <= cs_fall;
      cs_rise_q    <= cs_rise;
      tx_q         <= tx_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_act_q     <= tx_act_d;
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_o       = byte_q;
  assign cs_fall_o    = cs_fall_q;
  assign cs_rise_o    = cs_rise_q;
  assign miso_o       = tx_act_q & (LSB_FIRST ? tx_q[0] : tx_q[7]);

endmodule

// File: rtl/rebble_display_rx.sv
// Rebble display SPI frame receiver: command decode, framebuffer write port and status readback.
// Define REBBLE_ROW_ADDR_EN to make each row in DATA start with a row-index header byte.
module rebble_display_rx
  import rebble_display_pkg::*;
#(
  parameter int ROWS         = 168,
  parameter int COLS         = 144,
  parameter int BPP          = 1,
  parameter bit LSB_FIRST    = 1'b1,
  parameter int RESET_CYCLES = 16,
  localparam int TOTAL       = ROWS * COLS * BPP / 8,
  localparam int AW          = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          sck,
  input  logic          mosi,
  output logic          miso,
  output logic          reset_done,
  output logic          intn,
  output logic [AW-1:0] fb_addr,
  output logic [7:0]    fb_wdata,
  output logic          fb_we,
  output logic          busy
);

  localparam int            CW        = $clog2(RESET_CYCLES + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] init_cnt_q, init_cnt_d;
  logic [AW-1:0] addr_q, addr_d, fb_addr_q, fb_addr_d;
  logic [7:0]    fb_wdata_q, fb_wdata_d, tx_byte, rx_byte;
  logic          reset_done_q, reset_done_d, intn_q, intn_d, busy_q, busy_d;
  logic          err_q, err_d, fb_we_q, fb_we_d;
  logic          byte_valid, cs_fall, cs_rise, tx_load;

`ifdef REBBLE_ROW_ADDR_EN
  localparam int ROW_BYTES = COLS * BPP / 8;
  localparam int RBW       = $clog2(ROW_BYTES + 1);
  localparam int RW        = $clog2(ROWS + 1);
  logic           hdr_pend_q, hdr_pend_d, discard_q, discard_d;
  logic [RBW-1:0] row_left_q, row_left_d;
  logic [RW-1:0]  rows_done_q, rows_done_d;
`endif

  spi_byte_rx #(.LSB_FIRST(LSB_FIRST)) u_spi (
    .clk_i       (clk),
    .reset_i     (reset),
    .cs_i        (cs),
    .sck_i       (sck),
    .mosi_i      (mosi),
    .tx_load_i   (tx_load),
    .tx_byte_i   (tx_byte),
    .byte_valid_o(byte_valid),
    .byte_o      (rx_byte),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .miso_o      (miso)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    addr_d       = addr_q;
    reset_done_d = reset_done_q;
    intn_d       = intn_q;
    busy_d       = busy_q;
    err_d        = err_q;
    fb_we_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    tx_load      = 1'b0;
    tx_byte      = status_byte(err_q, ~intn_q, busy_q, reset_done_q);
`ifdef REBBLE_ROW_ADDR_EN
    hdr_pend_d   = hdr_pend_q;
    discard_d    = discard_q;
    row_left_d   = row_left_q;
    rows_done_d  = rows_done_q;
`endif
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CW'(RESET_CYCLES - 1)) begin
          reset_done_d = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          init_cnt_d = init_cnt_q + CW'(1);
        end
      end
      ST_IDLE: if (cs_fall) state_d = ST_CMD;
      ST_CMD: begin
        if (byte_valid) begin
          case (rx_byte)
            CMD_DRAW: begin
              state_d = ST_ARMED;
              busy_d  = 1'b1;
              addr_d  = '0;
`ifdef REBBLE_ROW_ADDR_EN
              hdr_pend_d  = 1'b1;
              rows_done_d = '0;
`endif
            end
            CMD_STATUS: begin
              // A status request cut off by cs rise has no byte to shift out.
              state_d = cs_rise ? ST_IDLE : ST_STAT;
              tx_load = ~cs_rise;
            end
            CMD_CLRINT: begin
              intn_d  = 1'b1;
              err_d   = 1'b0;
              state_d = ST_IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          endcase
        end else if (cs_rise) begin
          state_d = ST_IDLE;
        end
      end
      ST_ARMED: if (cs_fall) state_d = ST_DATA;
      ST_DATA: begin
        if (byte_valid) begin
`ifdef REBBLE_ROW_ADDR_EN
          if (hdr_pend_q) begin
            hdr_pend_d = 1'b0;
            row_left_d = RBW'(ROW_BYTES);
            if (int'(rx_byte) >= ROWS) begin
              err_d     = 1'b1;
              discard_d = 1'b1;
            end else begin
              discard_d = 1'b0;
              addr_d    = AW'(int'(rx_byte) * ROW_BYTES);
            end
          end else begin
            if (!discard_q) begin
              fb_we_d    = 1'b1;
              fb_addr_d  = addr_q;
              fb_wdata_d = rx_byte;
              addr_d     = addr_q + AW'(1);
            end
            row_left_d = row_left_q - RBW'(1);
            if (row_left_q == RBW'(1)) begin
              hdr_pend_d = 1'b1;
              if (!discard_q) begin
                if (rows_done_q == RW'(ROWS - 1)) begin
                  intn_d  = 1'b0;
                  busy_d  = 1'b0;
                  state_d = ST_IDLE;
                end else begin
                  rows_done_d = rows_done_q + RW'(1);
                end
              end
            end
          end
`else
          fb_we_d    = 1'b1;
          fb_addr_d  = addr_q;
          fb_wdata_d = rx_byte;
          if (addr_q == LAST_ADDR) begin
            intn_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_q + AW'(1);
          end
`endif
        end
        // The byte above is accepted first; the frame then waits for the next transaction.
        if (cs_rise && state_d == ST_DATA) state_d = ST_ARMED;
      end
      ST_STAT: if (byte_valid || cs_rise) state_d = ST_IDLE;
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      addr_q       <= '0;
      reset_done_q <= 1'b0;
      intn_q       <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      fb_we_q      <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      addr_q       <= addr_d;
      reset_done_q <= reset_done_d;
      intn_q       <= intn_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      fb_we_q      <= fb_we_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
    end
  end

`ifdef REBBLE_ROW_ADDR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_pend_q  <= 1'b1;
      discard_q   <= 1'b0;
      row_left_q  <= '0;
      rows_done_q <= '0;
    end else begin
      hdr_pend_q  <= hdr_pend_d;
      discard_q   <= discard_d;
      row_left_q  <= row_left_d;
      rows_done_q <= rows_done_d;
    end
  end
`endif

  assign reset_done = reset_done_q;
  assign intn       = intn_q;
  assign busy       = busy_q;
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;

endmodule

// File: tb/tb_rebble_display_rx.sv
// Directed bench for rebble_display_rx on a reduced 12x16 1-bpp panel (24-byte frame).
// Covers REBBLE_ROW_ADDR_EN behaviour as well when that macro is defined.
module tb_rebble_display_rx;

  localparam int ROWS  = 12;
  localparam int COLS  = 16;
  localparam int BPP   = 1;
  localparam int TOTAL = 24;
  localparam int AW    = 5;
  localparam int HALF  = 40;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cs = 1'b1;
  logic          sck = 1'b0;
  logic          mosi = 1'b0;
  logic          miso, resetDone, intn, fbWe, busy;
  logic [AW-1:0] fbAddr;
  logic [7:0]    fbWdata;

  int            compareCount = 0;
  int            mismatchCount = 0;
  int            wrAddr[$];
  logic [7:0]    wrData[$];
  logic [7:0]    statusByte;
  logic [7:0]    dummy;

  rebble_display_rx #(
    .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .LSB_FIRST(1'b1), .RESET_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso),
    .reset_done(resetDone), .intn(intn), .fb_addr(fbAddr), .fb_wdata(fbWdata),
    .fb_we(fbWe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Framebuffer write log, sampled on the falling edge away from the DUT's updates.
  always @(negedge clk) begin
    if (fbWe === 1'b1) begin
      wrAddr.push_back(int'(fbAddr));
      wrData.push_back(fbWdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic spiBits(input logic [7:0] b, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      mosi = b[i];
      #HALF;
      rx[i] = miso;
      sck = 1'b1;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    logic [7:0] unused;
    spiBits(b, 8, unused);
  endtask

  task automatic csBegin();
    cs = 1'b0;
    #(2 * HALF);
  endtask

  task automatic csEnd();
    #(2 * HALF);
    cs = 1'b1;
    #(4 * HALF);
  endtask

  task automatic sendCmd(input logic [7:0] op);
    csBegin();
    applyStimulus(op);
    csEnd();
  endtask

  task automatic readStatus(output logic [7:0] s);
    csBegin();
    applyStimulus(8'h03);
    spiBits(8'h00, 8, s);
    csEnd();
  endtask

  function automatic logic [7:0] expData(input int kind, input int i);
    if (kind == 0) return (i % 2 == 1) ? 8'hFF : 8'h00;
    return 8'(i * 7 + 3);
  endfunction

  task automatic checkWrites(input string tag, input int n, input int kind);
    int cnt;
    cnt = (wrAddr.size() < n) ? wrAddr.size() : n;
    checkOutput({tag, "_count"}, 32'(wrAddr.size()), 32'(n));
    for (int i = 0; i < cnt; i++) begin
      checkOutput($sformatf("%s_addr[%0d]", tag, i), 32'(wrAddr[i]), 32'(i));
      checkOutput($sformatf("%s_data[%0d]", tag, i), 32'(wrData[i]), 32'(expData(kind, i)));
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_reset_done", 32'(resetDone), 32'd0);
    checkOutput("rst_intn", 32'(intn), 32'd1);
    checkOutput("rst_miso", 32'(miso), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fb_we", 32'(fbWe), 32'd0);
    checkOutput("rst_fb_addr", 32'(fbAddr), 32'd0);
    checkOutput("rst_fb_wdata", 32'(fbWdata), 32'd0);
    repeat (8) @(negedge clk);
    checkOutput("init_reset_done_low", 32'(resetDone), 32'd0);
    repeat (12) @(negedge clk);
    checkOutput("init_reset_done_high", 32'(resetDone), 32'd1);

    // Frame 1: one transaction, two excess bytes after the last one.
    sendCmd(8'h05);
    checkOutput("f1_busy_armed", 32'(busy), 32'd1);
    checkOutput("f1_intn_armed", 32'(intn), 32'd1);
    csBegin();
    for (int i = 0; i < TOTAL + 2; i++) applyStimulus(expData(0, i));
    csEnd();
    checkWrites("f1", TOTAL, 0);
    checkOutput("f1_intn_done", 32'(intn), 32'd0);
    checkOutput("f1_busy_done", 32'(busy), 32'd0);

    readStatus(statusByte);
    checkOutput("stat_after_frame", 32'(statusByte), 32'h05);
    checkOutput("miso_idle", 32'(miso), 32'd0);
    sendCmd(8'h07);
    checkOutput("clrint_intn", 32'(intn), 32'd1);
    readStatus(statusByte);
    checkOutput("stat_after_clrint", 32'(statusByte), 32'h01);

    // Frame 2: split over three transactions with stray bits before the second cs rise.
    wrAddr.delete();
    wrData.delete();
    sendCmd(8'h05);
    csBegin();
    for (int i = 0; i < 8; i++) applyStimulus(expData(0, i));
    csEnd();
    csBegin();
    for (int i = 8; i < 16; i++) applyStimulus(expData(0, i));
    spiBits(8'h07, 3, dummy);
    csEnd();
    checkOutput("f2_intn_mid", 32'(intn), 32'd1);
    checkOutput("f2_busy_mid", 32'(busy), 32'd1);
    csBegin();
    for (int i = 16; i < TOTAL; i++) applyStimulus(expData(0, i));
    csEnd();
    checkWrites("f2", TOTAL, 0);
    checkOutput("f2_intn_done", 32'(intn), 32'd0);

    // Frame 3: DRAW while the interrupt is still pending keeps intn low.
    wrAddr.delete();
    wrData.delete();
    sendCmd(8'h05);
    checkOutput("f3_intn_held", 32'(intn), 32'd0);
    checkOutput("f3_busy_armed", 32'(busy), 32'd1);
    csBegin();
    for (int i = 0; i < TOTAL; i++) applyStimulus(expData(1, i));
    csEnd();
    checkWrites("f3", TOTAL, 1);
    checkOutput("f3_busy_done", 32'(busy), 32'd0);

    // Unknown opcode sets err without touching the framebuffer.
    sendCmd(8'h07);
    wrAddr.delete();
    wrData.delete();
    sendCmd(8'h42);
    checkOutput("badop_writes", 32'(wrAddr.size()), 32'd0);
    readStatus(statusByte);
    checkOutput("stat_badop", 32'(statusByte), 32'h09);
    sendCmd(8'h07);
    readStatus(statusByte);
    checkOutput("stat_err_cleared", 32'(statusByte), 32'h01);

    // Reset in the middle of a frame.
    sendCmd(8'h05);
    csBegin();
    for (int i = 0; i < 5; i++) applyStimulus(8'h5A);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_reset_done", 32'(resetDone), 32'd0);
    checkOutput("midrst_intn", 32'(intn), 32'd1);
    csEnd();
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("midrst_reinit", 32'(resetDone), 32'd1);
    wrAddr.delete();
    wrData.delete();
    sendCmd(8'h05);
    csBegin();
    applyStimulus(8'hA5);
    csEnd();
    checkOutput("midrst_count", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() > 0) begin
      checkOutput("midrst_addr", 32'(wrAddr[0]), 32'd0);
      checkOutput("midrst_data", 32'(wrData[0]), 32'hA5);
    end

`ifdef REBBLE_ROW_ADDR_EN
    // Row-addressed frame: row 2 lands at 4..5, out-of-range row 0xA8 is dropped.
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    wrAddr.delete();
    wrData.delete();
    sendCmd(8'h05);
    csBegin();
    applyStimulus(8'h02);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'hA8);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    csEnd();
    checkOutput("row_count", 32'(wrAddr.size()), 32'd2);
    if (wrAddr.size() >= 2) begin
      checkOutput("row_addr0", 32'(wrAddr[0]), 32'd4);
      checkOutput("row_addr1", 32'(wrAddr[1]), 32'd5);
      checkOutput("row_data0", 32'(wrData[0]), 32'h11);
      checkOutput("row_data1", 32'(wrData[1]), 32'h22);
    end
    checkOutput("row_intn_partial", 32'(intn), 32'd1);
    csBegin();
    for (int r = 0; r < ROWS; r++) begin
      if (r != 2) begin
        applyStimulus(8'(r));
        applyStimulus(8'h60);
        applyStimulus(8'h61);
      end
    end
    csEnd();
    checkOutput("row_total_writes", 32'(wrAddr.size()), 32'(TOTAL));
    checkOutput("row_intn_done", 32'(intn), 32'd0);
    readStatus(statusByte);
    checkOutput("row_stat", 32'(statusByte), 32'h0D);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
